// File: rtl/dpram_port_arbiter.sv
// Two-requester arbiter in front of a single DPRAM port: zero-latency grant,
// bounded-burst stickiness with round-robin fallback, one-cycle read return.
module dpram_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int MAX_BURST     = 4
) (
    input  logic                     AXI_clock,
    input  logic                     AXI_reset_n,

    input  logic                     rq0_req,
    input  logic                     rq0_we,
    input  logic [ADDRESS_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0]    rq0_wdata,
    output logic                     rq0_gnt,
    output logic                     rq0_rvalid,
    output logic [DATA_WIDTH-1:0]    rq0_rdata,

    input  logic                     rq1_req,
    input  logic                     rq1_we,
    input  logic [ADDRESS_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0]    rq1_wdata,
    output logic                     rq1_gnt,
    output logic                     rq1_rvalid,
    output logic [DATA_WIDTH-1:0]    rq1_rdata,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic       rr_last, rr_last_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;

    logic       grant_any;
    logic       win;
    state_t     win_state;

    // Winner selection and next-state; grants are masked while reset is held.
    always_comb begin
        grant_any     = 1'b0;
        win           = 1'b0;
        win_state     = GRANT0;
        state_nxt     = IDLE;
        rr_last_nxt   = rr_last;
        burst_cnt_nxt = '0;

        if (AXI_reset_n) begin
            if (rq0_req && rq1_req) begin
                grant_any = 1'b1;
                if (state == GRANT0 && burst_cnt < MAX_CNT)
                    win = 1'b0;
                else if (state == GRANT1 && burst_cnt < MAX_CNT)
                    win = 1'b1;
                else
                    win = ~rr_last;
            end else if (rq0_req) begin
                grant_any = 1'b1;
                win       = 1'b0;
            end else if (rq1_req) begin
                grant_any = 1'b1;
                win       = 1'b1;
            end
        end

        win_state = win ? GRANT1 : GRANT0;

        if (grant_any) begin
            state_nxt   = win_state;
            rr_last_nxt = win;
            if (state == win_state)
                burst_cnt_nxt = (burst_cnt < MAX_CNT) ? burst_cnt + 4'd1 : MAX_CNT;
            else
                burst_cnt_nxt = 4'd1;
        end
    end

    always_ff @(posedge AXI_clock or negedge AXI_reset_n) begin
        if (!AXI_reset_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_last_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign rq0_gnt  = grant_any & ~win;
    assign rq1_gnt  = grant_any &  win;

    assign mem_en   = grant_any;
    assign mem_we   = grant_any & (win ? rq1_we : rq0_we);
    assign mem_addr = win ? rq1_addr  : rq0_addr;
    assign mem_din  = win ? rq1_wdata : rq0_wdata;

    // Read-return tracking: the memory answers one cycle after an enabled read.
    always_ff @(posedge AXI_clock or negedge AXI_reset_n) begin
        if (!AXI_reset_n) begin
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;
        end else begin
            rq0_rvalid <= rq0_gnt & ~rq0_we;
            rq1_rvalid <= rq1_gnt & ~rq1_we;
        end
    end

    assign rq0_rdata = mem_dout;
    assign rq1_rdata = mem_dout;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural DPRAM and a read-return scoreboard.
module tb_dpram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          AXI_clock;
    logic          AXI_reset_n;
    logic          rq0_req, rq0_we, rq1_req, rq1_we;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [DW-1:0] rq0_wdata, rq1_wdata;
    logic          rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid;
    logic [DW-1:0] rq0_rdata, rq1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            valid;
        bit            who;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       sbq[$];
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    dpram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(4)) dut (
        .AXI_clock  (AXI_clock),
        .AXI_reset_n(AXI_reset_n),
        .rq0_req    (rq0_req),
        .rq0_we     (rq0_we),
        .rq0_addr   (rq0_addr),
        .rq0_wdata  (rq0_wdata),
        .rq0_gnt    (rq0_gnt),
        .rq0_rvalid (rq0_rvalid),
        .rq0_rdata  (rq0_rdata),
        .rq1_req    (rq1_req),
        .rq1_we     (rq1_we),
        .rq1_addr   (rq1_addr),
        .rq1_wdata  (rq1_wdata),
        .rq1_gnt    (rq1_gnt),
        .rq1_rvalid (rq1_rvalid),
        .rq1_rdata  (rq1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial AXI_clock = 1'b0;
    always #5 AXI_clock = ~AXI_clock;

    // Behavioural single-port RAM with registered read data.
    always @(posedge AXI_clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        rq0_req = r0; rq0_we = w0; rq0_addr = a0; rq0_wdata = d0;
        rq1_req = r1; rq1_we = w1; rq1_addr = a1; rq1_wdata = d1;
    endtask

    // One cycle: drive at negedge, check last cycle's read return and this cycle's grant.
    task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input bit eg0, input bit eg1, input string tag);
        rd_exp_t e;
        rd_exp_t n;
        @(negedge AXI_clock);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        #1;
        e = '{valid: 1'b0, who: 1'b0, data: '0};
        if (sbq.size() > 0) e = sbq.pop_front();
        check({tag, ".rvalid0"}, 32'(rq0_rvalid), 32'(e.valid && !e.who));
        check({tag, ".rvalid1"}, 32'(rq1_rvalid), 32'(e.valid &&  e.who));
        if (e.valid)
            check({tag, ".rdata"}, e.who ? rq1_rdata : rq0_rdata, e.data);
        check({tag, ".gnt0"},   32'(rq0_gnt), 32'(eg0));
        check({tag, ".gnt1"},   32'(rq1_gnt), 32'(eg1));
        check({tag, ".mem_en"}, 32'(mem_en),  32'(eg0 | eg1));
        n = '{valid: 1'b0, who: 1'b0, data: '0};
        if (eg0 | eg1) begin
            check({tag, ".mem_we"},   32'(mem_we),   32'(eg1 ? w1 : w0));
            check({tag, ".mem_addr"}, 32'(mem_addr), 32'(eg1 ? a1 : a0));
            if (eg1 ? w1 : w0) begin
                check({tag, ".mem_din"}, mem_din, eg1 ? d1 : d0);
                shadow[eg1 ? a1 : a0] = eg1 ? d1 : d0;
            end else begin
                n.valid = 1'b1;
                n.who   = eg1;
                n.data  = shadow[eg1 ? a1 : a0];
            end
        end
        sbq.push_back(n);
    endtask

    task automatic do_reset();
        @(negedge AXI_clock);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        AXI_reset_n = 1'b0;
        repeat (2) @(negedge AXI_clock);
        AXI_reset_n = 1'b1;
        sbq.delete();
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i]    = DW'(i * 7 + 1);
            shadow[i] = DW'(i * 7 + 1);
        end
        mem[5]    = 32'hDEADBEEF;
        shadow[5] = 32'hDEADBEEF;
        mem_dout  = '0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        AXI_reset_n = 1'b0;

        // Reset state, including requests held during reset.
        @(negedge AXI_clock);
        drive(1, 1, 10'd1, 32'h1, 1, 0, 10'd2, '0);
        #1;
        check("rst.gnt0",    32'(rq0_gnt),    0);
        check("rst.gnt1",    32'(rq1_gnt),    0);
        check("rst.mem_en",  32'(mem_en),     0);
        check("rst.mem_we",  32'(mem_we),     0);
        check("rst.rvalid0", 32'(rq0_rvalid), 0);
        check("rst.rvalid1", 32'(rq1_rvalid), 0);
        check("rst.burst",   32'(dut.burst_cnt), 0);
        do_reset();

        // Single read of 0xDEADBEEF by rq0.
        step(1, 0, 10'd5, '0, 0, 0, '0, '0, 1, 0, "single");
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "single_ret");

        // Write by rq0 then read of same word by rq1.
        step(1, 1, 10'd3, 32'h12345678, 0, 0, '0, '0, 1, 0, "mix_wr");
        step(0, 0, '0, '0, 1, 0, 10'd3, '0, 0, 1, "mix_rd");
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "mix_ret");

        // Back-to-back alternating single-requester reads.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1, 0, 10'(20 + i), '0, 0, 0, '0, '0, 1, 0, "alt");
            else            step(0, 0, '0, '0, 1, 0, 10'(40 + i), '0, 0, 1, "alt");
        end
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "alt_ret");

        // Continuous contention from reset: bursts of four, alternating.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 10'(100 + i), '0, 1, 0, 10'(200 + i), '0,
                 ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, "burst");
        end
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "burst_ret");

        // Yield: rq0 holds two cycles then drops while rq1 keeps requesting.
        do_reset();
        step(1, 0, 10'd7, '0, 1, 0, 10'd8, '0, 1, 0, "yield_a");
        step(1, 0, 10'd7, '0, 1, 0, 10'd8, '0, 1, 0, "yield_b");
        step(0, 0, '0,    '0, 1, 0, 10'd8, '0, 0, 1, "yield_c");
        @(posedge AXI_clock); #1;
        check("yield.burst", 32'(dut.burst_cnt), 1);
        step(1, 0, 10'd7, '0, 1, 0, 10'd9, '0, 0, 1, "yield_d");
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "yield_ret");

        // Reset arriving the cycle after a granted read drops the return.
        step(0, 0, '0, '0, 1, 0, 10'd5, '0, 0, 1, "rstrd");
        @(negedge AXI_clock);
        drive(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
        AXI_reset_n = 1'b0;
        #1;
        check("rstrd.gnt0",    32'(rq0_gnt),    0);
        check("rstrd.gnt1",    32'(rq1_gnt),    0);
        check("rstrd.mem_en",  32'(mem_en),     0);
        check("rstrd.rvalid1", 32'(rq1_rvalid), 0);
        @(negedge AXI_clock);
        check("rstrd.rvalid1b", 32'(rq1_rvalid), 0);
        check("rstrd.mem_enb",  32'(mem_en),     0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        AXI_reset_n = 1'b1;
        sbq.delete();
        step(1, 0, 10'd11, '0, 1, 0, 10'd12, '0, 1, 0, "post_rst");
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, "post_ret");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data words.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 10, word address width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive grants to one requester while the other waits; legal range 1..15.
REQ-004 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-005 AXI_clock  input  1  sole clock, all state on rising edge.
REQ-006 AXI_reset_n  input  1  asynchronous active-low reset.
REQ-007 rqN_req  input  1  requester N (N=0,1) access request, held until granted.
REQ-008 rqN_we  input  1  1 = write, 0 = read; valid with rqN_req.
REQ-009 rqN_addr  input  ADDRESS_WIDTH  word address.
REQ-010 rqN_wdata  input  DATA_WIDTH  write data.
REQ-011 rqN_gnt  output  1  access accepted this cycle.
REQ-012 rqN_rvalid  output  1  read data valid, one-cycle pulse.
REQ-013 rqN_rdata  output  DATA_WIDTH  read data, always equals mem_dout.
REQ-014 mem_en  output  1  DPRAM port enable.
REQ-015 mem_we  output  1  DPRAM port write enable.
REQ-016 mem_addr  output  ADDRESS_WIDTH  DPRAM port address.
REQ-017 mem_din  output  DATA_WIDTH  DPRAM write data.
REQ-018 mem_dout  input  DATA_WIDTH  DPRAM read data, valid 1 cycle after an enabled read.

Function
REQ-019 State machine SHALL have states IDLE (no grant last cycle), GRANT0, GRANT1 (grant to requester 0/1 last cycle), plus registers rr_last (1 bit) and burst_cnt (4 bits).
REQ-020 Winner SHALL be decided combinationally each cycle from registered state and current rqN_req; at most one rqN_gnt high per cycle.
REQ-021 Only one requester active: that requester SHALL be granted immediately (zero-cycle grant latency).
REQ-022 Both active, state GRANTn and burst_cnt < MAX_BURST: requester n SHALL win.
REQ-023 Both active, state IDLE or burst_cnt >= MAX_BURST: requester ~rr_last SHALL win.
REQ-024 On grant: mem_en=1, mem_we, mem_addr, mem_din SHALL be the winner's rqN_we/addr/wdata in the same cycle; otherwise mem_en=0, mem_we=0.
REQ-025 On grant to w: next state GRANTw, rr_last<=w; burst_cnt<=burst_cnt+1 saturating at MAX_BURST if previous state GRANTw, else burst_cnt<=1.
REQ-026 No grant: next state IDLE, burst_cnt<=0, rr_last unchanged.
REQ-027 Granted read SHALL cause rqw_rvalid=1 exactly one cycle later, rdata=mem_dout; writes produce no rvalid.
REQ-028 Back-to-back reads, including alternating requesters, SHALL each return rvalid to the correct requester one cycle after grant; throughput one access per cycle.
REQ-029 A requester dropping req SHALL not affect a read already granted.

Reset
REQ-030 Asserting AXI_reset_n low SHALL immediately force state IDLE, rr_last=1, burst_cnt=0, all rqN_rvalid=0.
REQ-031 While in reset, rqN_gnt=0, mem_en=0, mem_we=0 regardless of requests.
REQ-032 A read granted in the cycle before reset SHALL be dropped, no rvalid after reset release.
REQ-033 First grant after reset with both requesting SHALL go to requester 0.

Verification
REQ-034 Single: rq0 read addr 5, mem holds 0xDEADBEEF -> rq0_gnt same cycle, rq0_rvalid next cycle with 0xDEADBEEF, rq1_rvalid stays 0.
REQ-035 Contention: both requesting continuously, MAX_BURST=4 from reset -> grants 0,0,0,0,1,1,1,1,0,... .
REQ-036 Yield: rq0 holds 2 cycles then drops while rq1 requesting -> rq1 granted in the cycle rq0 drops, burst_cnt=1.
REQ-037 Mixed: rq0 writes 0x12345678 to addr 3, rq1 reads addr 3 next cycle -> rq1_rvalid returns 0x12345678.
REQ-038 Reset mid-read: rq1 read granted, AXI_reset_n low next cycle -> rq1_rvalid stays 0, mem_en=0 during reset; after release both request -> rq0 granted.
